mul_dot_accumulator: RTL and testbench
======================================

// Module: mul_dot_accumulator
// PURPOSE
//  Stage directly downstream of the 16x16 signed Wallace multiplier. Consumes a stream of
//  signed 32-bit products grouped by a 'last' marker; sums each group (dot product) in a wide
//  accumulator and emits one result per group over a valid/ready handshake.
//  Turns the combinational multiplier into a streaming MAC datapath for the ALU.
// PARAMETERS
//  PROD_W  32  width of incoming signed product (multiplier output)
//  ACC_W   40  accumulator width; guard bits = ACC_W-PROD_W; must be >= PROD_W
//  OUT_W   32  width of emitted result; must be <= ACC_W
//  CNT_W   8   width of per-group term counter
// PORTS
//  clk        in   1       clock; all state updates on rising edge
//  rst        in   1       reset, synchronous, active-high
//  clr        in   1       synchronous abort of current group / pending result
//  in_valid   in   1       product beat valid
//  in_ready   out  1       stage can accept a beat this cycle
//  in_prod    in   PROD_W  signed product from multiplier
//  in_last    in   1       beat is final term of its group
//  out_valid  out  1       group result valid
//  out_ready  in   1       consumer accepts result
//  out_data   out  OUT_W   signed group sum
//  out_count  out  CNT_W   number of terms in group
//  out_ovf    out  1       ACC_W overflow or counter saturation occurred in group
//  out_sat    out  1       out_data was clamped (0 unless MAC_SAT_EN)
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=ACC, acc=0, cnt=0, out_valid=0, out_data=0, out_count=0,
//    out_ovf=0, out_sat=0. Reset mid-group or with result pending discards everything.
//  - States: ACC (accumulating, no result pending), HOLD (result pending on out_*).
//  - in_ready = (state==ACC) | (state==HOLD & out_ready) -- combinational; no bubble between groups.
//  - Accept = in_valid & in_ready. On accept: acc_next = (cnt==0 ? 0 : acc) + sext(in_prod) mod 2^ACC_W;
//    cnt_next = cnt+1, saturating at 2^CNT_W-1 (saturation sets group ovf).
//  - Group ovf sticky: set on signed overflow of the ACC_W add (operand signs equal, sum sign differs).
//  - Accept with in_last=1: next cycle out_valid=1, out_data=fmt(acc_next), out_count=cnt_next,
//    out_ovf=group ovf; acc, cnt, ovf cleared; state->HOLD. Latency: 1 cycle last-beat -> out_valid.
//  - HOLD: out_* held stable until out_valid&out_ready; then state->ACC unless a new last beat is
//    accepted the same cycle (stay HOLD, new result loaded). Non-last beat in that cycle starts new group.
//  - Single-beat group (first beat has in_last) legal: out_count=1, out_data=fmt(sext(in_prod)).
//  - clr=1: acc=0, cnt=0, ovf=0, out_valid=0, state->ACC; beat presented same cycle is NOT accepted
//    (in_ready forced 0 while clr=1). rst overrides clr.
//  - fmt without MAC_SAT_EN: low OUT_W bits of acc (two's-complement wrap).
// CONFIGURATION
//  MAC_SAT_EN defined: fmt clamps acc to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_sat=1 when clamped.
//  MAC_SAT_EN undefined: wrap truncation as above; out_sat tied 0; no clamp logic synthesised.
// STRUCTURE
//  Shared header mul_defs.vh: PROD_W/ACC_W/OUT_W/CNT_W defaults, state encodings ST_ACC/ST_HOLD.
//  One sub-module: mac_sat_clamp (ACC_W -> OUT_W clamp + flag), instantiated only under MAC_SAT_EN.
// TESTING
//  - Group 3*4, -5*6, 7*8 (products 12,-30,56, last on 3rd) -> out_data=38, out_count=3, ovf=0.
//  - Single beat prod=-32768*-32768=1073741824, last=1 -> out_data=1073741824, out_count=1, 1-cycle latency.
//  - Four beats of 1073741824 -> sum 2^32: no MAC_SAT_EN out_data=0, sat=0; MAC_SAT_EN out_data=2147483647, sat=1.
//  - out_ready=0 for 5 cycles in HOLD -> out_* stable, in_ready=0; raise out_ready with new last beat
//    (prod=9) -> next cycle out_data=9, out_count=1, no idle cycle.
//  - 256 beats of prod=1 (CNT_W=8) -> out_count=255, out_ovf=1.
//  - clr after 2 beats of 100, then beat 5 last -> out_data=5; rst while HOLD -> out_valid=0 next cycle.

Source files
------------

// File: rtl/mul_dot_accumulator_pkg.sv
// ============================================================================
// Module   : mul_dot_accumulator_pkg
// Brief    : Shared widths and state encodings for the MAC dot-product stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_dot_accumulator_pkg;

    localparam int MAC_PROD_W = 32;
    localparam int MAC_ACC_W  = 40;
    localparam int MAC_OUT_W  = 32;
    localparam int MAC_CNT_W  = 8;

    localparam int              ST_W    = 1;
    localparam logic [ST_W-1:0] ST_ACC  = 1'b0;
    localparam logic [ST_W-1:0] ST_HOLD = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mac_sat_clamp.sv
// ============================================================================
// Module   : mac_sat_clamp
// Brief    : Clamps a signed ACC_W value into signed OUT_W range, flags clamping.
//            Compiled only when MAC_SAT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef MAC_SAT_EN
module mac_sat_clamp #(
    parameter int ACC_W = 40,
    parameter int OUT_W = 32
) (
    input  logic [ACC_W-1:0] acc,
    output logic [OUT_W-1:0] data,
    output logic             sat
);

    localparam logic signed [ACC_W-1:0] C_MAX = (ACC_W'(1) << (OUT_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] C_MIN = ~C_MAX;

    logic w_hi;
    logic w_lo;

    assign w_hi = $signed(acc) > C_MAX;
    assign w_lo = $signed(acc) < C_MIN;

    always_comb begin
        data = acc[OUT_W-1:0];
        sat  = 1'b0;
        if (w_hi) begin
            data = {1'b0, {(OUT_W-1){1'b1}}};
            sat  = 1'b1;
        end else if (w_lo) begin
            data = {1'b1, {(OUT_W-1){1'b0}}};
            sat  = 1'b1;
        end
    end

endmodule
`endif

`default_nettype wire

// File: rtl/mul_dot_accumulator.sv
// ============================================================================
// Module   : mul_dot_accumulator
// Brief    : Sums groups of signed products (last-delimited) and emits one
//            result per group over valid/ready. Optional MAC_SAT_EN clamps
//            the result to OUT_W instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_dot_accumulator
    import mul_dot_accumulator_pkg::*;
#(
    parameter int PROD_W = MAC_PROD_W,
    parameter int ACC_W  = MAC_ACC_W,
    parameter int OUT_W  = MAC_OUT_W,
    parameter int CNT_W  = MAC_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf,
    output logic              out_sat
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    logic [ST_W-1:0]  r_state;
    logic [ST_W-1:0]  w_state_next;

    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic [OUT_W-1:0] r_out_data;
    logic [CNT_W-1:0] r_out_count;
    logic             r_out_ovf;

    logic             w_accept;
    logic             w_release;
    logic [ACC_W-1:0] w_base;
    logic [ACC_W-1:0] w_sext;
    logic [ACC_W-1:0] w_sum;
    logic             w_add_ovf;
    logic             w_cnt_sat;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_ovf_next;
    logic [OUT_W-1:0] w_fmt_data;

    generate
        if (ACC_W > PROD_W) begin : g_sext_pad
            assign w_sext = {{(ACC_W-PROD_W){in_prod[PROD_W-1]}}, in_prod};
        end else begin : g_sext_none
            assign w_sext = in_prod;
        end
    endgenerate

    assign w_accept  = in_valid & in_ready;
    assign w_release = (r_state == ST_HOLD) & out_ready;

    // A zero count marks the first beat of a group, which starts from zero.
    assign w_base     = (r_cnt == '0) ? '0 : r_acc;
    assign w_sum      = w_base + w_sext;
    assign w_add_ovf  = (w_base[ACC_W-1] == w_sext[ACC_W-1]) &
                        (w_sum[ACC_W-1]  != w_base[ACC_W-1]);
    assign w_cnt_sat  = (r_cnt == C_CNT_MAX);
    assign w_cnt_next = w_cnt_sat ? r_cnt : r_cnt + CNT_W'(1);
    assign w_ovf_next = ((r_cnt != '0) & r_ovf) | w_add_ovf | w_cnt_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clr) begin
            w_state_next = ST_ACC;
        end else if (w_accept && in_last) begin
            w_state_next = ST_HOLD;
        end else if (w_release) begin
            w_state_next = ST_ACC;
        end
    end

    always_comb begin
        in_ready  = ~clr & ((r_state == ST_ACC) | w_release);
        out_valid = (r_state == ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else if (clr) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            if (in_last) begin
                r_acc       <= '0;
                r_cnt       <= '0;
                r_ovf       <= 1'b0;
                r_out_data  <= w_fmt_data;
                r_out_count <= w_cnt_next;
                r_out_ovf   <= w_ovf_next;
            end else begin
                r_acc <= w_sum;
                r_cnt <= w_cnt_next;
                r_ovf <= w_ovf_next;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_count = r_out_count;
    assign out_ovf   = r_out_ovf;

`ifdef MAC_SAT_EN
    logic w_fmt_sat;
    logic r_out_sat;

    mac_sat_clamp #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_clamp (
        .acc  (w_sum),
        .data (w_fmt_data),
        .sat  (w_fmt_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_sat <= 1'b0;
        end else if (!clr && w_accept && in_last) begin
            r_out_sat <= w_fmt_sat;
        end
    end

    assign out_sat = r_out_sat;
`else
    assign w_fmt_data = w_sum[OUT_W-1:0];
    assign out_sat    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mul_dot_accumulator.sv
// ============================================================================
// Module   : tb_mul_dot_accumulator
// Brief    : Bench for mul_dot_accumulator: directed cases plus random traffic
//            against an integer-arithmetic reference model. Honors MAC_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_dot_accumulator;

    localparam int PROD_W = 32;
    localparam int ACC_W  = 40;
    localparam int OUT_W  = 32;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clr = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic [PROD_W-1:0] in_prod = '0;
    logic              out_ready = 1'b1;
    logic              in_ready;
    logic              out_valid;
    logic [OUT_W-1:0]  out_data;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;
    logic              out_sat;

    int errors = 0;
    int checks = 0;

    mul_dot_accumulator #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W),
        .OUT_W  (OUT_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_ovf   (out_ovf),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic longint wrapn(input longint x, input int n);
        longint m;
        longint r;
        m = longint'(1) << n;
        r = x & (m - 1);
        if (r >= (m >>> 1)) r = r - m;
        return r;
    endfunction

    function automatic longint fmt(input longint x, output bit sat);
        longint hi;
        longint lo;
        hi  = (longint'(1) << (OUT_W - 1)) - 1;
        lo  = -(longint'(1) << (OUT_W - 1));
        sat = 1'b0;
`ifdef MAC_SAT_EN
        if (x > hi) begin
            sat = 1'b1;
            return hi;
        end
        if (x < lo) begin
            sat = 1'b1;
            return lo;
        end
        return x;
`else
        if (hi < lo) sat = 1'b1;
        return wrapn(x, OUT_W);
`endif
    endfunction

    // Reference model: pending result plus the running group, in plain integers.
    bit     m_ok = 1'b0;
    bit     m_pend;
    longint m_data;
    int     m_count;
    bit     m_ovf;
    bit     m_sat;
    int     g_cnt;
    longint g_sum;
    bit     g_ovf;

    initial begin
        forever begin
            bit     exp_ready;
            bit     ov;
            bit     s;
            int     cnt_n;
            longint base;
            longint raw;
            @(negedge clk);
            exp_ready = !clr && (!m_pend || out_ready);
            if (m_ok) begin
                check("in_ready", longint'(in_ready), longint'(exp_ready));
                check("out_valid", longint'(out_valid), longint'(m_pend));
                if (m_pend) begin
                    check("out_data", longint'($signed(out_data)), m_data);
                    check("out_count", longint'(out_count), longint'(m_count));
                    check("out_ovf", longint'(out_ovf), longint'(m_ovf));
                    check("out_sat", longint'(out_sat), longint'(m_sat));
                end
            end
            if (rst) begin
                m_ok = 1'b1; m_pend = 1'b0; m_data = 0; m_count = 0;
                m_ovf = 1'b0; m_sat = 1'b0; g_cnt = 0; g_sum = 0; g_ovf = 1'b0;
            end else if (!m_ok) begin
                m_ok = 1'b0;
            end else if (clr) begin
                m_pend = 1'b0; g_cnt = 0; g_sum = 0; g_ovf = 1'b0;
            end else begin
                if (m_pend && out_ready) m_pend = 1'b0;
                if (in_valid && exp_ready) begin
                    base = (g_cnt == 0) ? 0 : g_sum;
                    ov   = (g_cnt == 0) ? 1'b0 : g_ovf;
                    raw  = base + longint'($signed(in_prod));
                    if (raw != wrapn(raw, ACC_W)) ov = 1'b1;
                    if (g_cnt == (1 << CNT_W) - 1) begin
                        ov    = 1'b1;
                        cnt_n = g_cnt;
                    end else begin
                        cnt_n = g_cnt + 1;
                    end
                    if (in_last) begin
                        m_pend  = 1'b1;
                        m_data  = fmt(wrapn(raw, ACC_W), s);
                        m_sat   = s;
                        m_count = cnt_n;
                        m_ovf   = ov;
                        g_cnt = 0; g_sum = 0; g_ovf = 1'b0;
                    end else begin
                        g_sum = wrapn(raw, ACC_W);
                        g_cnt = cnt_n;
                        g_ovf = ov;
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [PROD_W-1:0] p, input logic last);
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = last;
        cyc();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        logic signed [15:0] a;
        logic signed [15:0] b;

        repeat (3) cyc();
        rst = 1'b0;
        check("rst_valid", longint'(out_valid), 0);
        check("rst_data", longint'(out_data), 0);
        check("rst_count", longint'(out_count), 0);
        check("rst_ovf", longint'(out_ovf), 0);

        beat(32'd12, 1'b0);
        beat(-32'sd30, 1'b0);
        beat(32'd56, 1'b1);
        check("grp_valid", longint'(out_valid), 1);
        check("grp_data", longint'($signed(out_data)), 38);
        check("grp_count", longint'(out_count), 3);
        check("grp_ovf", longint'(out_ovf), 0);

        beat(32'd1073741824, 1'b1);
        check("one_valid", longint'(out_valid), 1);
        check("one_data", longint'($signed(out_data)), 1073741824);
        check("one_count", longint'(out_count), 1);

        repeat (3) beat(32'd1073741824, 1'b0);
        beat(32'd1073741824, 1'b1);
`ifdef MAC_SAT_EN
        check("big_data", longint'($signed(out_data)), 2147483647);
        check("big_sat", longint'(out_sat), 1);
`else
        check("big_data", longint'($signed(out_data)), 0);
        check("big_sat", longint'(out_sat), 0);
`endif
        check("big_count", longint'(out_count), 4);

        beat(32'd7, 1'b1);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_prod  = 32'd123;
            in_last  = 1'b1;
            #2;
            check("hold_ready", longint'(in_ready), 0);
            cyc();
        end
        check("hold_data", longint'($signed(out_data)), 7);
        check("hold_valid", longint'(out_valid), 1);
        out_ready = 1'b1;
        beat(32'd9, 1'b1);
        check("b2b_data", longint'($signed(out_data)), 9);
        check("b2b_count", longint'(out_count), 1);
        check("b2b_valid", longint'(out_valid), 1);

        for (int i = 0; i < 255; i++) beat(32'd1, 1'b0);
        beat(32'd1, 1'b1);
        check("sat_count", longint'(out_count), 255);
        check("sat_ovf", longint'(out_ovf), 1);
        check("sat_data", longint'($signed(out_data)), 256);

        beat(32'd100, 1'b0);
        beat(32'd100, 1'b0);
        clr = 1'b1;
        in_valid = 1'b1;
        in_prod  = 32'd100;
        cyc();
        clr = 1'b0;
        in_valid = 1'b0;
        check("clr_valid", longint'(out_valid), 0);
        beat(32'd5, 1'b1);
        check("clr_data", longint'($signed(out_data)), 5);
        check("clr_count", longint'(out_count), 1);

        beat(32'd3, 1'b1);
        out_ready = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rsthold_valid", longint'(out_valid), 0);

        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_last   = ($urandom_range(0, 4) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            clr       = ($urandom_range(0, 63) == 0);
            rst       = ($urandom_range(0, 511) == 0);
            if ($urandom_range(0, 1) == 0) begin
                in_prod = $urandom;
            end else begin
                a = 16'($urandom);
                b = 16'($urandom);
                in_prod = 32'(int'(a) * int'(b));
            end
            cyc();
        end
        in_valid  = 1'b0;
        clr       = 1'b0;
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (4) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
